// File: rtl/uart_rx_modport.sv
// uart_rx_modport: asynchronous serial receiver with run-time frame format.
// Deserializes 5-8 data bits LSB-first with optional even/odd parity and
// 1 or 2 stop bits. The frame format is captured when the start bit is seen.
//
// Ports:
//   clk           system clock, rising-edge active
//   reset_n       asynchronous active-low reset
//   rx            serial input line (idles high, asynchronous to clk)
//   data_bit_num  data bits per frame: 00=5, 01=6, 10=7, 11=8
//   stop_bit_num  0 = one stop bit, 1 = two stop bits
//   parity_en     1 = frame carries a parity bit after the data bits
//   parity_type   0 = even, 1 = odd
//   rx_data       last received word, right-aligned, upper bits zero
//   rts_n         low while the receiver is idle and ready
//   rx_done       one-cycle pulse when a frame completes
//   parity_error  parity status of the last completed frame
module uart_rx_modport #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic [7:0] rx_data,
    output logic       rts_n,
    output logic       rx_done,
    output logic       parity_error
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shift_reg;
    logic          perr_calc;

    // Frame format captured at the start bit
    logic [1:0]    cfg_bits;
    logic          cfg_stop;
    logic          cfg_par_en;
    logic          cfg_par_type;

    // Index of the last data bit is N-1 = 4 + data_bit_num
    logic [2:0]    last_idx;
    assign last_idx = {1'b1, cfg_bits};

    // Two-flop synchronizer; resets to the idle line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM. After the start-bit midpoint check the bit counter is
    // restarted, so every later wrap of cnt lands on the midpoint of the
    // next bit. rts_n goes low one cycle after the IDLE return, i.e. in the
    // cycle after the rx_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shift_reg    <= '0;
            perr_calc    <= 1'b0;
            cfg_bits     <= '0;
            cfg_stop     <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_par_type <= 1'b0;
            rx_data      <= 8'h00;
            rts_n        <= 1'b0;
            rx_done      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    rts_n <= 1'b0;
                    if (!rx_s) begin
                        state        <= START;
                        rts_n        <= 1'b1;
                        cnt          <= '0;
                        bit_idx      <= '0;
                        stop_idx     <= 1'b0;
                        shift_reg    <= '0;
                        perr_calc    <= 1'b0;
                        cfg_bits     <= data_bit_num;
                        cfg_stop     <= stop_bit_num;
                        cfg_par_en   <= parity_en;
                        cfg_par_type <= parity_type;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == last_idx) begin
                            state <= cfg_par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        // Unused upper shift bits are zero, so a full-width
                        // XOR covers exactly the received data bits.
                        perr_calc <= (^shift_reg) ^ rx_s ^ cfg_par_type;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (stop_idx == cfg_stop) begin
                            rx_data      <= shift_reg;
                            parity_error <= cfg_par_en & perr_calc;
                            rx_done      <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_modport.sv
// tb_uart_rx_modport: scoreboard bench for uart_rx_modport. The stimulus
// task drives whole serial frames and queues the expected word, parity flag
// and completion cycle; an independent monitor pops and compares on rx_done.
module tb_uart_rx_modport;

    localparam int CPB = 16;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] rx_data;
    logic       rts_n;
    logic       rx_done;
    logic       parity_error;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;

    uart_rx_modport #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .rx_data      (rx_data),
        .rts_n        (rts_n),
        .rx_done      (rx_done),
        .parity_error (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: compares every rx_done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_done) begin
                done_count++;
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("[TB] FAIL done_width: got 2+ cycles expected 1");
                end
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_done: got rx_done=1 expected none at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("rx_data", rx_data, e.data);
                    checkOutput("parity_error", {7'd0, parity_error}, {7'd0, e.perr});
                    checks++;
                    if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                        failures++;
                        $display("[TB] FAIL done_latency: got cycle %0d expected %0d", cyc, e.cyc);
                    end
                end
            end
        end
        prev_done = rx_done;
    end

    task automatic driveBit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Sends one frame. abort_at >= 0 pulls reset during that data bit and
    // returns without expecting a completion.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] dbn,
                                 input logic pen, input logic ptype,
                                 input logic sbn, input logic pbit,
                                 input logic [7:0] exp_data, input logic exp_perr,
                                 input int abort_at);
        int   nb;
        int   bits;
        int   t0;
        exp_t e;
        data_bit_num = dbn;
        parity_en    = pen;
        parity_type  = ptype;
        stop_bit_num = sbn;
        @(posedge clk);
        #1;
        nb   = 5 + int'(dbn);
        bits = nb + int'(pen) + int'(sbn) + 1;
        t0   = cyc + 1;
        if (abort_at < 0) begin
            e.data = exp_data;
            e.perr = exp_perr;
            e.cyc  = t0 + 2 + CPB / 2 + CPB * bits;
            sb.push_back(e);
        end
        driveBit(1'b0);
        checkOutput("rts_n_busy", {7'd0, rts_n}, 8'd1);
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                rx = data[i];
                repeat (8) @(posedge clk);
                #1;
                reset_n = 1'b0;
                repeat (3) @(posedge clk);
                rx = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset_n = 1'b1;
                return;
            end
            driveBit(data[i]);
        end
        if (pen) driveBit(pbit);
        driveBit(1'b1);
        if (sbn) driveBit(1'b1);
        rx = 1'b1;
    endtask

    initial begin
        int dc;
        reset_n      = 1'b0;
        rx           = 1'b1;
        data_bit_num = 2'b11;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("idle_rts_n", {7'd0, rts_n}, 8'd0);
        checkOutput("idle_rx_done", {7'd0, rx_done}, 8'd0);
        checkOutput("idle_rx_data", rx_data, 8'h00);
        checkOutput("idle_parity_error", {7'd0, parity_error}, 8'd0);

        // 8N1 0xA5
        applyStimulus(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("rts_n_after_8n1", {7'd0, rts_n}, 8'd0);
        checkOutput("done_count_8n1", 8'(done_count), 8'd1);

        // 7E1 0x55: four ones, even parity bit 0 is correct, 1 is wrong
        applyStimulus(8'h55, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, -1);
        repeat (20) @(posedge clk);
        applyStimulus(8'h55, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, -1);
        repeat (20) @(posedge clk);

        // 5O2 5'b10110: three ones, odd parity bit 0 is correct
        applyStimulus(8'h16, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h16, 1'b0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("done_count_5o2", 8'(done_count), 8'd4);

        // 4-cycle glitch: rejected at the start-bit midpoint
        dc = done_count;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("glitch_done_count", 8'(done_count), 8'(dc));
        checkOutput("glitch_rx_data", rx_data, 8'h16);
        checkOutput("glitch_rts_n", {7'd0, rts_n}, 8'd0);

        // Reset during the 4th data bit (index 3)
        applyStimulus(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3);
        repeat (3 * CPB) @(posedge clk);
        #1;
        checkOutput("abort_done_count", 8'(done_count), 8'(dc));
        checkOutput("abort_rx_data", rx_data, 8'h00);
        checkOutput("abort_parity_error", {7'd0, parity_error}, 8'd0);
        checkOutput("abort_rts_n", {7'd0, rts_n}, 8'd0);

        // Recovery frame after the abort
        applyStimulus(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("final_done_count", 8'(done_count), 8'(dc + 1));
        checkOutput("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
